// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and constants: FSM encoding, the NOP instruction
// and the default reset PC.
package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    TRAP
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/next_pc_mux.sv
// Next-PC selection: branch/jump target (bit 0 forced low) or sequential PC+4,
// with a misalignment flag for targets that are not word aligned.
module next_pc_mux
  import riscv_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        next_pc_src,
  input  logic [31:0] branch_target,
  output logic [31:0] next_pc,
  output logic        misalign
);

  // Bit 0 of the target is discarded, as JALR requires.
  logic unused_target_lsb;
  assign unused_target_lsb = branch_target[0];

  assign next_pc  = next_pc_src ? {branch_target[31:1], 1'b0} : pc + 32'd4;
  assign misalign = next_pc[1];

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch unit: owns the PC, fetches over a req/valid port, holds each instruction
// for the datapath and advances the PC on accept; traps on misalign or timeout.
module fetch_pc_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        NextPCSrc,
  input  logic [31:0] BranchTarget,
  input  logic        InstrReady,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemValid,
  input  logic [31:0] ImemRData,
  output logic [31:0] Instr,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        InstrValid,
  output logic        MisalignErr,
  output logic        TimeoutErr
);

  localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;

  fetch_state_t    state, state_nxt;
  logic [31:0]     pc, instr, next_pc;
  logic [WD_W-1:0] watchdog;
  logic            misalign, accept, miss, wd_expire;
  logic            misalign_err, timeout_err;

  next_pc_mux u_next_pc_mux (
    .pc           (pc),
    .next_pc_src  (NextPCSrc),
    .branch_target(BranchTarget),
    .next_pc      (next_pc),
    .misalign     (misalign)
  );

  assign accept    = (state == HOLD) && InstrReady;
  assign miss      = (state == FETCH) && !ImemValid;
  assign wd_expire = (TIMEOUT != 0) && miss && (watchdog == WD_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt  = state;
    ImemReq    = 1'b0;
    InstrValid = 1'b0;
    unique case (state)
      IDLE:  state_nxt = FETCH;
      FETCH: begin
        ImemReq = 1'b1;
        if (ImemValid)      state_nxt = HOLD;
        else if (wd_expire) state_nxt = TRAP;
      end
      HOLD: begin
        InstrValid = 1'b1;
        if (accept) state_nxt = misalign ? TRAP : FETCH;
      end
      TRAP:    state_nxt = TRAP;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc           <= RESET_PC;
      instr        <= NOP_INSTR;
      watchdog     <= '0;
      misalign_err <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      if (state == FETCH) begin
        if (ImemValid) begin
          instr    <= ImemRData;
          watchdog <= '0;
        end else if (watchdog != '1) begin
          watchdog <= watchdog + 1'b1;
        end
      end
      if (wd_expire) timeout_err <= 1'b1;
      // NextPCSrc/BranchTarget only matter here, so X elsewhere is harmless.
      if (accept) begin
        if (misalign) misalign_err <= 1'b1;
        else          pc           <= next_pc;
      end
    end
  end

  assign ImemAddr    = pc;
  assign PC          = pc;
  assign PCPlus4     = pc + 32'd4;
  assign Instr       = instr;
  assign MisalignErr = misalign_err;
  assign TimeoutErr  = timeout_err;

endmodule
